// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the RV32 load/store unit.
// Covers funct3 access sizes, fault codes, FSM states and the classification helpers.
package load_store_unit_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    function automatic logic isIllegalOp(input logic isRead, input logic isWrite,
                                         input logic [2:0] f3);
        logic badLoad;
        logic badStore;
        badLoad  = isRead && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        badStore = isWrite && f3[2];
        return (isRead == isWrite) || badLoad || badStore;
    endfunction

    // Bytes can never be misaligned; halfwords need an even address, words a multiple of 4.
    function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] byteOff);
        return (f3[1:0] == 2'b01 && byteOff[0]) || (f3[1:0] == 2'b10 && byteOff != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering between the 32-bit data bus and sub-word accesses.
// Stores are replicated into every lane with a strobe; loads select a lane and extend it.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byteOff,
    input  logic [31:0] i_storeData,
    input  logic [31:0] i_loadWord,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_loadData
);

    logic [15:0] w_shifted;

    assign w_shifted = 16'(i_loadWord >> {i_byteOff, 3'b000});

    always_comb begin
        o_wdata = i_storeData;
        o_wstrb = 4'b1111;
        case (i_funct3[1:0])
            2'b00: begin
                o_wdata = {4{i_storeData[7:0]}};
                o_wstrb = 4'b0001 << i_byteOff;
            end
            2'b01: begin
                o_wdata = {2{i_storeData[15:0]}};
                o_wstrb = i_byteOff[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_loadData = i_loadWord;
        case (i_funct3)
            F3_BYTE:   o_loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_HALF:   o_loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BYTE_U: o_loadData = {24'b0, w_shifted[7:0]};
            F3_HALF_U: o_loadData = {16'b0, w_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-phase unit for RV32 loads/stores: classifies a request, runs the data-bus
// handshake with a timeout, and returns one response pulse per accepted request.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        resp_valid,
    output logic        resp_we,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic [1:0]  fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e     r_state;
    logic           r_isLoad;
    logic [2:0]     r_funct3;
    logic [1:0]     r_byteOff;
    logic [4:0]     r_rd;
    logic [CW-1:0]  r_count;

    logic           r_reqReady;
    logic           r_respValid;
    logic           r_respWe;
    logic [4:0]     r_respRd;
    logic [31:0]    r_respData;
    logic [1:0]     r_fault;
    logic           r_dmemReq;
    logic           r_dmemWe;
    logic [31:0]    r_dmemAddr;
    logic [31:0]    r_dmemWdata;
    logic [3:0]     r_dmemWstrb;

    logic [2:0]     w_alignFunct3;
    logic [1:0]     w_alignOff;
    logic [31:0]    w_wdata;
    logic [3:0]     w_wstrb;
    logic [31:0]    w_loadData;

    // The aligner sees the live request while idle and the latched access afterwards.
    assign w_alignFunct3 = (r_state == ST_IDLE) ? funct3 : r_funct3;
    assign w_alignOff    = (r_state == ST_IDLE) ? addr[1:0] : r_byteOff;

    lsu_lane_align u_align (
        .i_funct3    (w_alignFunct3),
        .i_byteOff   (w_alignOff),
        .i_storeData (store_data),
        .i_loadWord  (dmem_rdata),
        .o_wdata     (w_wdata),
        .o_wstrb     (w_wstrb),
        .o_loadData  (w_loadData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_isLoad    <= 1'b0;
            r_funct3    <= 3'b000;
            r_byteOff   <= 2'b00;
            r_rd        <= 5'd0;
            r_count     <= '0;
            r_reqReady  <= 1'b1;
            r_respValid <= 1'b0;
            r_respWe    <= 1'b0;
            r_respRd    <= 5'd0;
            r_respData  <= 32'd0;
            r_fault     <= FAULT_NONE;
            r_dmemReq   <= 1'b0;
            r_dmemWe    <= 1'b0;
            r_dmemAddr  <= 32'd0;
            r_dmemWdata <= 32'd0;
            r_dmemWstrb <= 4'b0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_isLoad   <= mem_read;
                        r_funct3   <= funct3;
                        r_byteOff  <= addr[1:0];
                        r_rd       <= rd;
                        r_reqReady <= 1'b0;
                        // Faulting requests respond directly and never touch the bus.
                        if (isIllegalOp(mem_read, mem_write, funct3) ||
                            isMisaligned(funct3, addr[1:0])) begin
                            r_state     <= ST_RESP;
                            r_respValid <= 1'b1;
                            r_respWe    <= 1'b0;
                            r_respRd    <= rd;
                            r_respData  <= 32'd0;
                            r_fault     <= isIllegalOp(mem_read, mem_write, funct3) ?
                                           FAULT_ILLEGAL : FAULT_MISALIGN;
                        end else begin
                            r_state     <= ST_REQ;
                            r_count     <= '0;
                            r_dmemReq   <= 1'b1;
                            r_dmemWe    <= mem_write;
                            r_dmemAddr  <= {addr[31:2], 2'b00};
                            r_dmemWdata <= mem_write ? w_wdata : 32'd0;
                            r_dmemWstrb <= mem_write ? w_wstrb : 4'b0000;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) begin
                        r_dmemReq <= 1'b0;
                        r_count   <= '0;
                        if (r_isLoad) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state     <= ST_RESP;
                            r_respValid <= 1'b1;
                            r_respWe    <= 1'b0;
                            r_respRd    <= r_rd;
                            r_respData  <= 32'd0;
                            r_fault     <= FAULT_NONE;
                        end
                    end else if (r_count == LAST_COUNT) begin
                        r_dmemReq   <= 1'b0;
                        r_state     <= ST_RESP;
                        r_respValid <= 1'b1;
                        r_respWe    <= 1'b0;
                        r_respRd    <= r_rd;
                        r_respData  <= 32'd0;
                        r_fault     <= FAULT_TIMEOUT;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        r_state     <= ST_RESP;
                        r_respValid <= 1'b1;
                        r_respWe    <= 1'b1;
                        r_respRd    <= r_rd;
                        r_respData  <= w_loadData;
                        r_fault     <= FAULT_NONE;
                    end else if (r_count == LAST_COUNT) begin
                        r_state     <= ST_RESP;
                        r_respValid <= 1'b1;
                        r_respWe    <= 1'b0;
                        r_respRd    <= r_rd;
                        r_respData  <= 32'd0;
                        r_fault     <= FAULT_TIMEOUT;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_reqReady  <= 1'b1;
                    r_respValid <= 1'b0;
                    r_respWe    <= 1'b0;
                    r_respRd    <= 5'd0;
                    r_respData  <= 32'd0;
                    r_fault     <= FAULT_NONE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_reqReady <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_reqReady;
    assign resp_valid = r_respValid;
    assign resp_we    = r_respWe;
    assign resp_rd    = r_respRd;
    assign resp_data  = r_respData;
    assign fault      = r_fault;
    assign dmem_req   = r_dmemReq;
    assign dmem_we    = r_dmemWe;
    assign dmem_addr  = r_dmemAddr;
    assign dmem_wdata = r_dmemWdata;
    assign dmem_wstrb = r_dmemWstrb;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// requests compared against an arithmetic reference model of the access rules.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        resp_valid;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic [1:0]  fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int passCount = 0;
    int checkCount = 0;

    typedef struct packed {
        int          latency;
        int          reqCycles;
        logic [1:0]  fault;
        logic [31:0] data;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic        busWe;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        stable;
        logic        pulseOk;
        logic        ready;
    } obs_t;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr),
        .store_data(store_data), .rd(rd), .resp_valid(resp_valid), .resp_we(resp_we),
        .resp_rd(resp_rd), .resp_data(resp_data), .fault(fault), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired got running want finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        req_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0;
        store_data = 0; rd = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    // Reference: the expected observation derived from the access rules with plain arithmetic.
    function automatic obs_t model(input logic rdOp, input logic wrOp, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] sd,
                                   input logic [4:0] rdIdx, input logic [31:0] word,
                                   input int g, input int r);
        obs_t e;
        int off;
        int size;
        longint v;
        longint span;
        bit illegal;
        e = '0;
        e.rd = rdIdx; e.stable = 1; e.pulseOk = 1; e.ready = 1;
        off = int'(a % 4);
        size = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
        illegal = (rdOp == wrOp) || (rdOp && (f3 == 3 || f3 == 6 || f3 == 7)) || (wrOp && f3 >= 4);
        if (illegal) begin e.fault = 2; e.latency = 1; return e; end
        if (off % size != 0) begin e.fault = 1; e.latency = 1; return e; end
        span = longint'(1) << (8 * size);
        e.addr = a - off;
        e.busWe = wrOp;
        if (wrOp) begin
            e.wstrb = 4'(((1 << size) - 1) << off);
            v = {32'b0, sd} % span;
            e.wdata = 32'(v * ((size == 1) ? 64'h01010101 : ((size == 2) ? 64'h00010001 : 64'h1)));
        end
        if (g >= TO) begin
            e.reqCycles = TO; e.fault = 3; e.latency = TO + 1; return e;
        end
        e.reqCycles = g + 1;
        if (wrOp) begin e.latency = g + 2; return e; end
        if (r >= TO) begin e.fault = 3; e.latency = g + 2 + TO; return e; end
        v = ({32'b0, word} >> (8 * off)) % span;
        if (f3 < 4 && size < 4 && v >= span / 2) v = v - span;
        e.data = v[31:0];
        e.we = 1;
        e.latency = g + 3 + r;
        return e;
    endfunction

    // Issues one request, plays the bus (grant after g REQ cycles, read data r cycles into WAIT).
    task automatic applyStimulus(input logic rdOp, input logic wrOp, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [4:0] rdIdx, input logic [31:0] word,
                                 input int g, input int r, input bit junk, output obs_t o);
        int gntN;
        bit seen;
        o = '0; o.latency = -1; o.stable = 1; gntN = -1; seen = 0;
        mem_read = rdOp; mem_write = wrOp; funct3 = f3; addr = a; store_data = sd; rd = rdIdx;
        dmem_gnt = 0; dmem_rvalid = 0;
        req_valid = 1;
        tick();
        req_valid = 0;
        mem_read = 1'($urandom); mem_write = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; store_data = $urandom; rd = 5'($urandom);
        for (int n = 1; n <= 60; n++) begin
            if (seen) begin
                o.pulseOk = !resp_valid;
                o.ready = req_ready;
                break;
            end
            if (resp_valid) begin
                seen = 1; o.latency = n; o.fault = fault; o.data = resp_data;
                o.we = resp_we; o.rd = resp_rd;
            end
            dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = $urandom;
            if (dmem_req) begin
                o.reqCycles = o.reqCycles + 1;
                if (o.reqCycles == 1) begin
                    o.addr = dmem_addr; o.busWe = dmem_we; o.wdata = dmem_wdata; o.wstrb = dmem_wstrb;
                end else if (dmem_addr !== o.addr || dmem_we !== o.busWe ||
                             dmem_wdata !== o.wdata || dmem_wstrb !== o.wstrb) begin
                    o.stable = 0;
                end
                if (o.reqCycles - 1 == g) begin
                    dmem_gnt = 1; gntN = n;
                    if (junk) dmem_rvalid = 1;
                end
            end
            if (gntN > 0 && n == gntN + 1 + r) begin
                dmem_rvalid = 1; dmem_rdata = word;
            end
            tick();
        end
        dmem_gnt = 0; dmem_rvalid = 0;
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1; tick(); tick(); rst = 0;
        checkCount++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", req_ready); else passCount++;
        checkCount++; if (resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); else passCount++;
        checkCount++; if (dmem_req !== 1'b0) $display("[TB] FAIL reset_dmem_req got %b want 0", dmem_req); else passCount++;
        checkCount++; if ({fault, resp_we, resp_rd, resp_data} !== 40'd0) $display("[TB] FAIL reset_resp_fields got %h want 0", {fault, resp_we, resp_rd, resp_data}); else passCount++;
        checkCount++; if ({dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== 69'd0) $display("[TB] FAIL reset_bus_fields got %h want 0", {dmem_we, dmem_addr, dmem_wdata, dmem_wstrb}); else passCount++;
    endtask

    task automatic test_store_byte();
        obs_t o;
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h1003, 32'h000000A5, 5'd7, 32'h0, 0, 0, 1'b0, o);
        checkCount++; if (o.addr !== 32'h1000) $display("[TB] FAIL sb_addr got %h want 00001000", o.addr); else passCount++;
        checkCount++; if (o.wstrb !== 4'b1000) $display("[TB] FAIL sb_wstrb got %b want 1000", o.wstrb); else passCount++;
        checkCount++; if (o.wdata !== 32'hA5A5A5A5) $display("[TB] FAIL sb_wdata got %h want a5a5a5a5", o.wdata); else passCount++;
        checkCount++; if (o.busWe !== 1'b1) $display("[TB] FAIL sb_bus_we got %b want 1", o.busWe); else passCount++;
        checkCount++; if (o.latency != 2) $display("[TB] FAIL sb_latency got %0d want 2", o.latency); else passCount++;
        checkCount++; if ({o.we, o.fault} !== 3'b000) $display("[TB] FAIL sb_we_fault got %b want 000", {o.we, o.fault}); else passCount++;
        checkCount++; if (o.pulseOk !== 1'b1) $display("[TB] FAIL sb_pulse got %b want 1", o.pulseOk); else passCount++;
    endtask

    task automatic test_load_byte();
        obs_t o;
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 5'd13, 32'h000080FF, 0, 0, 1'b0, o);
        checkCount++; if (o.data !== 32'hFFFFFF80) $display("[TB] FAIL lb_data got %h want ffffff80", o.data); else passCount++;
        checkCount++; if (o.we !== 1'b1 || o.rd !== 5'd13) $display("[TB] FAIL lb_we_rd got %b/%0d want 1/13", o.we, o.rd); else passCount++;
        checkCount++; if (o.latency != 3) $display("[TB] FAIL lb_latency got %0d want 3", o.latency); else passCount++;
        checkCount++; if (o.wstrb !== 4'b0000 || o.busWe !== 1'b0) $display("[TB] FAIL lb_bus got %b/%b want 0000/0", o.wstrb, o.busWe); else passCount++;
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h2001, 32'h0, 5'd13, 32'h000080FF, 0, 0, 1'b0, o);
        checkCount++; if (o.data !== 32'h00000080) $display("[TB] FAIL lbu_data got %h want 00000080", o.data); else passCount++;
    endtask

    task automatic test_misaligned();
        obs_t o;
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h3003, 32'h0, 5'd9, 32'h12345678, 0, 0, 1'b0, o);
        checkCount++; if (o.fault !== 2'b01) $display("[TB] FAIL lh_mis_fault got %b want 01", o.fault); else passCount++;
        checkCount++; if (o.latency != 1) $display("[TB] FAIL lh_mis_latency got %0d want 1", o.latency); else passCount++;
        checkCount++; if (o.reqCycles != 0) $display("[TB] FAIL lh_mis_bus got %0d req cycles want 0", o.reqCycles); else passCount++;
        checkCount++; if (o.we !== 1'b0) $display("[TB] FAIL lh_mis_we got %b want 0", o.we); else passCount++;
    endtask

    task automatic test_illegal();
        obs_t o;
        applyStimulus(1'b1, 1'b0, 3'b011, 32'h4000, 32'h0, 5'd4, 32'h0, 0, 0, 1'b0, o);
        checkCount++; if (o.fault !== 2'b10 || o.latency != 1) $display("[TB] FAIL ill_f3_fault got %b@%0d want 10@1", o.fault, o.latency); else passCount++;
        checkCount++; if (o.reqCycles != 0) $display("[TB] FAIL ill_f3_bus got %0d want 0", o.reqCycles); else passCount++;
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h4000, 32'h0, 5'd4, 32'h0, 0, 0, 1'b0, o);
        checkCount++; if (o.fault !== 2'b10 || o.latency != 1) $display("[TB] FAIL ill_rw_fault got %b@%0d want 10@1", o.fault, o.latency); else passCount++;
        checkCount++; if (o.reqCycles != 0 || o.we !== 1'b0) $display("[TB] FAIL ill_rw_bus got %0d/%b want 0/0", o.reqCycles, o.we); else passCount++;
    endtask

    task automatic test_timeout();
        obs_t o;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 5'd2, 32'h0, 99, 0, 1'b0, o);
        checkCount++; if (o.fault !== 2'b11 || o.latency != TO + 1) $display("[TB] FAIL to_req got %b@%0d want 11@%0d", o.fault, o.latency, TO + 1); else passCount++;
        checkCount++; if (o.reqCycles != TO) $display("[TB] FAIL to_req_cycles got %0d want %0d", o.reqCycles, TO); else passCount++;
        checkCount++; if (o.ready !== 1'b1 || o.we !== 1'b0) $display("[TB] FAIL to_req_idle got %b/%b want 1/0", o.ready, o.we); else passCount++;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 5'd2, 32'h0, 0, 99, 1'b0, o);
        checkCount++; if (o.fault !== 2'b11 || o.latency != TO + 2) $display("[TB] FAIL to_wait got %b@%0d want 11@%0d", o.fault, o.latency, TO + 2); else passCount++;
        checkCount++; if (o.reqCycles != 1 || o.ready !== 1'b1) $display("[TB] FAIL to_wait_bus got %0d/%b want 1/1", o.reqCycles, o.ready); else passCount++;
    endtask

    task automatic test_reset_mid();
        int sawResp;
        sawResp = 0;
        mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h6000; rd = 5'd3;
        req_valid = 1; tick(); req_valid = 0;
        checkCount++; if (dmem_req !== 1'b1) $display("[TB] FAIL rst_req_pre got %b want 1", dmem_req); else passCount++;
        rst = 1; tick(); rst = 0;
        checkCount++; if (dmem_req !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL rst_req_drop got %b/%b want 0/1", dmem_req, req_ready); else passCount++;
        req_valid = 1; tick(); req_valid = 0;
        dmem_gnt = 1; tick(); dmem_gnt = 0;
        rst = 1; tick(); rst = 0;
        dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
        for (int n = 0; n < 4; n++) begin
            tick();
            dmem_rvalid = 0;
            if (resp_valid) sawResp++;
        end
        checkCount++; if (sawResp != 0) $display("[TB] FAIL rst_wait_resp got %0d pulses want 0", sawResp); else passCount++;
        checkCount++; if (req_ready !== 1'b1 || dmem_req !== 1'b0) $display("[TB] FAIL rst_wait_state got %b/%b want 1/0", req_ready, dmem_req); else passCount++;
        checkCount++; if ({fault, resp_we, resp_data, dmem_addr, dmem_wstrb} !== 71'd0) $display("[TB] FAIL rst_wait_outputs got %h want 0", {fault, resp_we, resp_data, dmem_addr, dmem_wstrb}); else passCount++;
    endtask

    task automatic test_late_bus();
        int bad;
        bad = 0;
        idleInputs();
        dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h55AA55AA;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (resp_valid || dmem_req || !req_ready) bad++;
        end
        dmem_gnt = 0; dmem_rvalid = 0;
        checkCount++; if (bad != 0) $display("[TB] FAIL late_bus got %0d disturbed cycles want 0", bad); else passCount++;
    endtask

    task automatic test_back_to_back();
        int respIdx[$];
        int readyInResp;
        readyInResp = 0;
        mem_read = 0; mem_write = 1; funct3 = 3'b010; addr = 32'h7000; store_data = 32'h11223344; rd = 5'd1;
        req_valid = 1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (resp_valid) begin
                respIdx.push_back(n);
                if (req_ready) readyInResp++;
            end
            dmem_gnt = dmem_req;
            if (n == 12) req_valid = 0;
        end
        dmem_gnt = 0;
        tick(); tick(); tick();
        checkCount++; if (respIdx.size() != 4) $display("[TB] FAIL b2b_count got %0d want 4", respIdx.size()); else passCount++;
        checkCount++; if (respIdx.size() < 2 || respIdx[1] - respIdx[0] != 3) $display("[TB] FAIL b2b_gap got %0d want 3", (respIdx.size() < 2) ? -1 : respIdx[1] - respIdx[0]); else passCount++;
        checkCount++; if (readyInResp != 0) $display("[TB] FAIL b2b_ready_in_resp got %0d want 0", readyInResp); else passCount++;
    endtask

    task automatic test_random();
        obs_t o;
        obs_t e;
        logic rdOp, wrOp;
        logic [2:0] f3;
        logic [31:0] a, sd, word;
        logic [4:0] rdIdx;
        int g, r, mode;
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 9);
            if (mode == 0) begin rdOp = 1'($urandom); wrOp = rdOp; end
            else begin rdOp = 1'($urandom); wrOp = !rdOp; end
            f3 = 3'($urandom_range(0, 7));
            a = $urandom; sd = $urandom; word = $urandom; rdIdx = 5'($urandom);
            if (i % 3 != 0) a[1:0] = 2'b00;
            g = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            r = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            e = model(rdOp, wrOp, f3, a, sd, rdIdx, word, g, r);
            applyStimulus(rdOp, wrOp, f3, a, sd, rdIdx, word, g, r, 1'($urandom), o);
            checkCount++; if (o.latency != e.latency || o.fault !== e.fault) $display("[TB] FAIL rnd%0d_latency_fault got %0d/%b want %0d/%b", i, o.latency, o.fault, e.latency, e.fault); else passCount++;
            checkCount++; if (o.data !== e.data || o.we !== e.we || o.rd !== e.rd) $display("[TB] FAIL rnd%0d_resp got %h/%b/%0d want %h/%b/%0d", i, o.data, o.we, o.rd, e.data, e.we, e.rd); else passCount++;
            checkCount++; if (o.reqCycles != e.reqCycles) $display("[TB] FAIL rnd%0d_req_cycles got %0d want %0d", i, o.reqCycles, e.reqCycles); else passCount++;
            if (e.reqCycles > 0) begin
                checkCount++; if (o.addr !== e.addr || o.busWe !== e.busWe || o.wdata !== e.wdata || o.wstrb !== e.wstrb || o.stable !== 1'b1) $display("[TB] FAIL rnd%0d_bus got %h/%b/%h/%b/%b want %h/%b/%h/%b/1", i, o.addr, o.busWe, o.wdata, o.wstrb, o.stable, e.addr, e.busWe, e.wdata, e.wstrb); else passCount++;
            end
            checkCount++; if (o.pulseOk !== 1'b1 || o.ready !== 1'b1) $display("[TB] FAIL rnd%0d_pulse got %b/%b want 1/1", i, o.pulseOk, o.ready); else passCount++;
        end
    endtask

    initial begin
        rst = 1;
        idleInputs();
        test_reset();
        test_store_byte();
        test_load_byte();
        test_misaligned();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_late_bus();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Executes the memory phase of RV32 loads and stores flagged by the decoder's mem_read/mem_write.
- Accepts one request at a time from the execute stage. Address comes from the ALU add result.
- Drives a word-wide data-memory bus with a request/grant/read-valid handshake.
- Returns aligned, sign/zero-extended load data, or a fault code, to writeback. It stalls the pipeline while busy.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles spent waiting in REQ or WAIT before a bus-error fault (minimum 2).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready
- mem_read  in  1  load (from decoder)
- mem_write  in  1  store (from decoder)
- funct3  in  3  access size/sign
- addr  in  32  byte address (rs1+imm)
- store_data  in  32  rs2 value
- rd  in  5  load destination register
- resp_valid  out  1  one-cycle completion pulse
- resp_we  out  1  register-file write enable; high only for a successful load
- resp_rd  out  5  destination register
- resp_data  out  32  extended load data, 0 for stores/faults
- fault  out  2  00 none, 01 misaligned, 10 illegal op, 11 bus timeout
- dmem_req  out  1  bus request, held until dmem_gnt
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address: addr with [1:0] = 00
- dmem_wdata  out  32  store data replicated into lanes
- dmem_wstrb  out  4  byte enables, 0000 for reads
- dmem_gnt  in  1  bus accepted request this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data

Behaviour:
- Reset: state = IDLE; req_ready = 1; every other output = 0; timeout counter = 0.
- States are IDLE, REQ, WAIT and RESP.
- IDLE, on transfer: latch op, funct3, addr[1:0], rd, bus fields, then classify.
  - Illegal op: mem_read && mem_write; neither set; load funct3 in {011,110,111}; store funct3[2]=1. Go to RESP with fault 10.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠00. Go to RESP with fault 01.
  - Faulting ops never assert dmem_req.
  - Otherwise go to REQ.
- REQ: dmem_req = 1; address, we, wdata and wstrb stay stable until grant.
  - On dmem_gnt: a store goes to RESP; a load goes to WAIT.
  - dmem_rvalid in the same cycle as dmem_gnt is not accepted; it is ignored.
- WAIT: on dmem_rvalid, extract and extend the data, latch it, go to RESP.
- Timeout: the counter resets on entry to REQ and to WAIT. When it reaches TIMEOUT_CYCLES, go to RESP with fault 11 and drop dmem_req.
- RESP: resp_valid = 1 for exactly one cycle.
  - resp_we = 1 only for a load with fault 00; resp_rd is the latched rd.
  - Next state is IDLE.
- Lanes: byte k = addr[1:0].
  - SB: wstrb = 1<<k, wdata = {4{b}}.
  - SH: wstrb = 0011 or 1100, wdata = {2{h}}.
  - SW: wstrb = 1111.
  - LB/LH sign-extend the selected lane; LBU/LHU zero-extend it; LW passes through.
- Latency with immediate grant, accept at cycle T:
  - Store: dmem_req at T+1; resp_valid at T+2.
  - Load: rvalid at T+2 gives resp_valid at T+3.
  - Fault: resp_valid at T+1.
- Boundaries:
  - rst mid-transaction: dmem_req falls in the following cycle.
  - Any late dmem_gnt/dmem_rvalid arriving in IDLE is ignored.
  - req_valid while busy is not consumed; the upstream stage holds it.
  - req_ready is 0 in RESP, so back-to-back requests see a one-cycle bubble.

Decomposition:
- Shared package:
  - funct3 load/store encodings
  - state enum
  - fault code constants
  - load/store opcode values shared with the decoder
- One sub-module: lsu_lane_align. It is combinational:
  - store lane replication and strobe generation
  - load lane selection and extension

Test Plan:
- SB addr=0x1003, data=0x000000A5, gnt immediate → dmem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5; resp_valid at T+2, resp_we=0, fault=00.
- LB addr=0x2001, rdata=0x0000_80FF, rvalid one cycle after gnt → resp_data=0xFFFFFF80, resp_we=1, resp_rd as sent. Repeat as LBU → 0x00000080.
- LH addr=0x3003 → fault=01 at T+1, dmem_req never asserted, resp_we=0.
- Load with funct3=011, and separately mem_read=mem_write=1 → fault=10, no bus activity.
- LW with dmem_gnt held 0 → after 16 cycles in REQ: fault=11, dmem_req drops, returns to IDLE. Repeat with gnt given but rvalid withheld (timeout from WAIT).
- Assert rst while in WAIT, then pulse dmem_rvalid → no resp_valid, outputs at reset values, req_ready=1.
